// File: rtl/data_memory_responder.sv
// Word-wide data memory with a fixed-latency request/response handshake.
// Each accepted request completes after WAIT wait states with a one-cycle ready pulse.
module data_memory_responder #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h10010000,
  parameter int          WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_L = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        err_q, err_d;
  logic        rd_valid_q, rd_valid_d;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic [29:0] word_off;
  logic        below_base;
  logic        in_range;
  logic        aligned;
  logic        acc_ok;
  logic [IDX_W-1:0] acc_idx;
  logic        enter_done;
  logic [31:0] rd_word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (reset) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            capture = 1'b1;
            if (WAIT == 0) begin
              state_d = DONE;
            end else begin
              state_d = WAITING;
              cnt_d   = WAIT_L;
            end
          end
        end
        WAITING: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // With WAIT=0 the memory access happens on the accepting edge itself, so the
  // live inputs are used there; otherwise the captured copy is used.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_be    = be;
    end
  end

  assign word_off   = acc_addr[31:2] - BASE[31:2];
  assign below_base = (acc_addr < BASE);
  assign in_range   = !below_base && ({2'b00, word_off} < 32'(DEPTH));
  assign aligned    = (acc_addr[1:0] == 2'b00);
  assign acc_ok     = aligned && in_range;
  assign acc_idx    = word_off[IDX_W-1:0];
  assign enter_done = (state_d == DONE) && (state_q != DONE);

  always_comb begin
    err_d      = err_q;
    rd_valid_d = rd_valid_q;
    if (enter_done) begin
      err_d      = !acc_ok;
      rd_valid_d = acc_ok && !acc_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      if (capture) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
    end
  end

  // One byte-wide array per lane; memory contents survive reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
        if (enter_done && acc_ok && acc_we && acc_be[gi]) begin
          lane_mem[acc_idx] <= acc_wdata[8*gi +: 8];
        end
        if (enter_done && acc_ok && !acc_we) begin
          lane_rd_q <= lane_mem[acc_idx];
        end
      end

      assign rd_word[8*gi +: 8] = lane_rd_q;
    end
  endgenerate

  assign busy  = (state_q != IDLE);
  assign ready = (state_q == DONE);
  assign err   = ready && err_q;
  assign rdata = (ready && rd_valid_q) ? rd_word : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: cycle-level reference model plus directed accesses.
module tb_data_memory_responder;

  localparam int          WAIT  = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h10010000;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        busy, ready, err;
  logic [31:0] rdata;

  logic        req0;
  logic        busy0, ready0, err0;
  logic [31:0] rdata0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(DEPTH), .BASE(BASE), .WAIT(WAIT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .busy(busy), .ready(ready), .rdata(rdata), .err(err)
  );

  data_memory_responder #(.DEPTH(DEPTH), .BASE(BASE), .WAIT(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .req(req0), .we(1'b1), .addr(32'h10010010),
    .wdata(32'hCAFEF00D), .be(4'hF), .busy(busy0), .ready(ready0),
    .rdata(rdata0), .err(err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding access, accepted only when the previous
  // one has fully retired, answered WAIT edges after acceptance.
  int          edge_n = 0;
  int          next_free = 0;
  bit          pv = 0;
  int          p_ready = 0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  logic [31:0] r_rdata = 32'd0;
  bit          r_err = 0;
  bit          r_known = 1;
  logic [31:0] mmem [int];
  bit          mknown [int];

  task automatic model_respond();
    bit   ok;
    int   idx;
    logic [31:0] w;
    ok = (p_addr[1:0] == 2'b00) && (p_addr >= BASE) && (((p_addr - BASE) >> 2) < DEPTH);
    r_err   = !ok;
    r_rdata = 32'd0;
    r_known = 1;
    if (ok) begin
      idx = int'((p_addr - BASE) >> 2);
      if (p_we) begin
        w = mknown.exists(idx) ? mmem[idx] : 32'd0;
        for (int b = 0; b < 4; b++)
          if (p_be[b]) w[8*b +: 8] = p_wdata[8*b +: 8];
        if (mknown.exists(idx) || p_be == 4'hF) begin
          mmem[idx]   = w;
          mknown[idx] = 1;
        end
      end else if (mknown.exists(idx)) begin
        r_rdata = mmem[idx];
      end else begin
        r_known = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (pv && edge_n > p_ready) pv = 0;
    if (reset) begin
      pv        = 0;
      next_free = edge_n + 1;
    end else if (!pv && req && edge_n >= next_free) begin
      pv        = 1;
      p_ready   = edge_n + WAIT;
      next_free = edge_n + WAIT + 2;
      p_we      = we;
      p_addr    = addr;
      p_wdata   = wdata;
      p_be      = be;
    end
    if (!reset && pv && edge_n == p_ready) model_respond();
  end

  always @(negedge clk) begin
    bit exp_busy, exp_ready;
    exp_busy  = pv && (edge_n <= p_ready);
    exp_ready = pv && (edge_n == p_ready);
    check("model busy", 32'(busy), 32'(exp_busy));
    check("model ready", 32'(ready), 32'(exp_ready));
    check("model err", 32'(err), exp_ready ? 32'(r_err) : 32'd0);
    if (!exp_ready || r_known)
      check("model rdata", rdata, exp_ready ? r_rdata : 32'd0);
  end

  // Issue one access, scramble the inputs while busy, and check the response.
  task automatic access(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    bit got;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    got = 0;
    lat = 21;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom; be = 4'($urandom);
      end
      if (ready) begin
        got = 1;
        lat = i;
        break;
      end
    end
    check({name, " ready seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(lat), 32'd3);
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " rdata"}, rdata, exp_rd);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'h0;
    req0  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset rdata", rdata, 32'd0);
    reset = 1'b0;

    access("wr 004", 1'b1, 32'h10010004, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0);
    access("rd 004", 1'b0, 32'h10010004, 32'd0, 4'h0, 1'b0, 32'hDEADBEEF);
    access("wr 008", 1'b1, 32'h10010008, 32'h11223344, 4'hF, 1'b0, 32'd0);
    access("wr 008 lane1", 1'b1, 32'h10010008, 32'hAABBCCDD, 4'b0010, 1'b0, 32'd0);
    access("rd 008 merged", 1'b0, 32'h10010008, 32'd0, 4'h0, 1'b0, 32'h1122CC44);
    access("wr 000", 1'b1, 32'h10010000, 32'h0BADF00D, 4'hF, 1'b0, 32'd0);
    access("rd misaligned", 1'b0, 32'h10010002, 32'd0, 4'h0, 1'b1, 32'd0);
    access("rd past end", 1'b0, 32'h10011000, 32'd0, 4'h0, 1'b1, 32'd0);
    access("rd below base", 1'b0, 32'h1000FFFC, 32'd0, 4'h0, 1'b1, 32'd0);
    access("wr past end", 1'b1, 32'h10011000, 32'h99999999, 4'hF, 1'b1, 32'd0);
    access("wr misaligned", 1'b1, 32'h10010006, 32'h77777777, 4'hF, 1'b1, 32'd0);
    access("rd 000 no wrap", 1'b0, 32'h10010000, 32'd0, 4'h0, 1'b0, 32'h0BADF00D);
    access("rd 004 after err", 1'b0, 32'h10010004, 32'd0, 4'h0, 1'b0, 32'hDEADBEEF);
    access("wr 004 be0", 1'b1, 32'h10010004, 32'h00000000, 4'h0, 1'b0, 32'd0);
    access("rd 004 after be0", 1'b0, 32'h10010004, 32'd0, 4'h0, 1'b0, 32'hDEADBEEF);
    access("rd last word", 1'b1, 32'h10010FFC, 32'h0F0F0F0F, 4'hF, 1'b0, 32'd0);
    access("rd last word", 1'b0, 32'h10010FFC, 32'd0, 4'h0, 1'b0, 32'h0F0F0F0F);

    // Write aborted by reset in its first waiting cycle.
    access("wr 00C", 1'b1, 32'h1001000C, 32'h55667788, 4'hF, 1'b0, 32'd0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h1001000C; wdata = 32'h99999999; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    check("abort busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    check("abort no ready", 32'(cnt), 32'd0);
    access("rd 00C old", 1'b0, 32'h1001000C, 32'd0, 4'h0, 1'b0, 32'h55667788);

    // Reset wins over a request at the same edge.
    @(negedge clk);
    reset = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h10010004; wdata = 32'h12345678; be = 4'hF;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    check("reset+req busy", 32'(busy), 32'd0);

    // Request while busy is ignored; the response reflects the captured read.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10010004; be = 4'h0;
    cnt = 21;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        we = 1'b1; addr = 32'h10010008; wdata = 32'hFFFFFFFF; be = 4'hF;
      end
      if (i == 2) req = 1'b0;
      if (ready) begin
        cnt = i;
        break;
      end
    end
    check("busy req latency", 32'(cnt), 32'd3);
    check("busy req rdata", rdata, 32'hDEADBEEF);
    access("rd 008 untouched", 1'b0, 32'h10010008, 32'd0, 4'h0, 1'b0, 32'h1122CC44);
    access("rd 004 untouched", 1'b0, 32'h10010004, 32'd0, 4'h0, 1'b0, 32'hDEADBEEF);

    // Zero-wait instance: req held for 10 edges gives 5 back-to-back accesses.
    @(negedge clk);
    req0 = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check($sformatf("w0 ready cyc%0d", i), 32'(ready0), 32'(i % 2));
      check($sformatf("w0 busy cyc%0d", i), 32'(busy0), 32'(i % 2));
      if (ready0) begin
        cnt++;
        check($sformatf("w0 err cyc%0d", i), 32'(err0), 32'd0);
        check($sformatf("w0 rdata cyc%0d", i), rdata0, 32'd0);
      end
    end
    req0 = 1'b0;
    @(negedge clk);
    check("w0 idle after", 32'(busy0), 32'd0);
    check("w0 access count", 32'(cnt), 32'd5);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the number of 32-bit words stored.
REQ-002 Parameter BASE, default 32'h10010000, SHALL set the byte address of word 0.
REQ-003 Parameter WAIT, default 2, range 0..15, SHALL set the wait states inserted per access.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 req  input  1  SHALL be the request strobe from the datapath.
REQ-007 we  input  1  SHALL select write (1) or read (0).
REQ-008 addr  input  32  SHALL be the byte address (the datapath's aluout).
REQ-009 wdata  input  32  SHALL be the store data (the datapath's writedata).
REQ-010 be  input  4  SHALL be the byte enables for writes; be[i] covers wdata[8i+7:8i].
REQ-011 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-012 ready  output  1  SHALL be a one-cycle response pulse.
REQ-013 rdata  output  32  SHALL carry read data, valid only while ready=1.
REQ-014 err  output  1  SHALL flag a rejected access, valid only while ready=1.

Function
REQ-015 The FSM SHALL use the states IDLE, WAITING and DONE.
REQ-016 In IDLE with req=1, the block SHALL capture we, addr, wdata and be at the edge.
REQ-017 On that capture it SHALL go to WAITING, loading a down-counter with WAIT, or go directly to DONE when WAIT=0.
REQ-018 In WAITING the counter SHALL decrement each cycle; on the edge where the counter equals 1, the FSM SHALL go to DONE.
REQ-019 ready=1 SHALL hold for exactly the one DONE cycle; the FSM then returns to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: ready rises WAIT+1 cycles after the accepting edge.
REQ-021 The peak rate SHALL be one access per WAIT+2 cycles.
REQ-022 req SHALL be ignored in WAITING and DONE; no queuing takes place.
REQ-023 In WAITING and DONE, changes on we, addr, wdata or be SHALL have no effect; captured values are used.
REQ-024 Index = (addr - BASE) >> 2.
REQ-025 An access SHALL be in range iff addr >= BASE and index < DEPTH, with no wrap-around modulo DEPTH.
REQ-026 A misaligned address (addr[1:0] != 0) or an out-of-range address SHALL give err=1, rdata=0 and no write in DONE.
REQ-027 A valid write SHALL update only the enabled byte lanes at the edge entering DONE; rdata SHALL be 0.
REQ-028 A write with be=4'b0000 SHALL complete normally with err=0 and leave memory unchanged.
REQ-029 A valid read SHALL register mem[index] at the edge entering DONE and drive it on rdata during DONE.
REQ-030 A read following a write to the same word SHALL return the merged, post-write contents.
REQ-031 rdata and err SHALL be 0 in every cycle where ready=0.
REQ-032 busy SHALL equal 0 exactly in IDLE, so that busy=0 and req=1 means the request is accepted at the next edge.

Reset
REQ-033 With reset=1 at an edge, the next state SHALL be IDLE, the counter 0, and busy, ready, err and rdata 0.
REQ-034 Reset SHALL take priority over any req sampled at the same edge.
REQ-035 Reset during WAITING SHALL abort the access; a pending write SHALL NOT modify memory and no ready pulse SHALL follow.
REQ-036 Reset SHALL NOT clear memory contents.

Verification
REQ-037 WAIT=2, write addr=0x10010004, wdata=0xDEADBEEF, be=4'hF, then read 0x10010004 -> each ready arrives 3 cycles after acceptance; read gives rdata=0xDEADBEEF, err=0.
REQ-038 Word 0x10010008 set to 0x11223344, then write be=4'b0010, wdata=0xAABBCCDD, then read -> rdata=0x1122CC44.
REQ-039 Read addr=0x10010002, and separately read addr=0x10011000 with DEPTH=1024 -> err=1, rdata=0; memory unchanged.
REQ-040 WAIT=0, req held high for 10 cycles -> ready pulses every 2nd cycle, busy toggles 1/0, 5 accesses total.
REQ-041 Write to 0x1001000C with reset asserted in the first WAITING cycle, then read 0x1001000C -> no ready for the aborted write; read returns the old value.
REQ-042 req asserted while busy=1 with a different addr -> ignored; the response reflects only the captured request.
